pwm_bank: RTL

Parametrised multi-channel PWM generator: one shared period counter drives CH independent edge-aligned compare channels. Period and per-channel duty are written through a simple register port into shadow registers and take effect only at a period boundary, so updates never produce a glitch or a truncated pulse. It sits between the control logic (or a soft-CPU register bridge) and the board PWM pins, replacing fixed-constant single-channel PWM.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_channel.sv | 48 ++++
 rtl/pwm_bank.sv | 90 +++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and config-address helpers for the pwm_bank PWM generator.
package pwm_pkg;

    localparam int unsigned ADDR_PERIOD    = 0;
    localparam int unsigned ADDR_DUTY_BASE = 1;

    // Maps a config address to a channel index; addresses past the last channel
    // map to indices that no channel matches.
    function automatic int unsigned chan_of_addr(input int unsigned addr);
        return addr - ADDR_DUTY_BASE;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One edge-aligned compare channel: shadow/active duty pair and a registered PWM bit.
module pwm_channel #(
    parameter int          WIDTH        = 16,
    parameter int unsigned DEFAULT_DUTY = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [WIDTH-1:0] cnt_i,
    output logic             pwm_o
);

    logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [WIDTH-1:0] duty_act_q, duty_act_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        duty_sh_d  = duty_sh_q;
        duty_act_d = duty_act_q;
        if (we_i) begin
            duty_sh_d = wdata_i;
        end
        if (load_i) begin
            duty_act_d = duty_sh_q;
        end
        pwm_d = en_i && (cnt_i < duty_act_q);
    end

    // NOTE: every register here has an async reset value, so outputs drop low the
    // moment rst rises regardless of the clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_sh_q  <= WIDTH'(DEFAULT_DUTY);
            duty_act_q <= WIDTH'(DEFAULT_DUTY);
            pwm_q      <= 1'b0;
        end else begin
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM: shared period counter, shadowed period/duty registers that
// take effect only at a period wrap, and CH compare channels.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int          CH             = 4,
    parameter int          WIDTH          = 16,
    parameter int unsigned DEFAULT_PERIOD = 19999,
    parameter int unsigned DEFAULT_DUTY   = 10000,
    parameter int          ADDR_W         = $clog2(CH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [WIDTH-1:0]  cfg_wdata,
    output logic [CH-1:0]     pwm_out,
    output logic              period_done
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_sh_q, period_sh_d;
    logic [WIDTH-1:0] period_act_q, period_act_d;
    logic             period_done_q, period_done_d;
    logic             wrap;
    logic             load;
    logic [31:0]      addr_ext;
    logic [CH-1:0]    ch_we;

    assign addr_ext = 32'(cfg_addr);
    assign wrap     = enable && (cnt_q == period_act_q);
    // While disabled the active set tracks the shadows so the first period after
    // enable already uses the latest writes.
    assign load     = !enable || wrap;

    always_comb begin
        cnt_d         = cnt_q + WIDTH'(1);
        period_sh_d   = period_sh_q;
        period_act_d  = period_act_q;
        period_done_d = wrap;
        if (!enable || wrap) begin
            cnt_d = '0;
        end
        if (cfg_we && (addr_ext == ADDR_PERIOD)) begin
            period_sh_d = cfg_wdata;
        end
        if (load) begin
            period_act_d = period_sh_q;
        end
    end

    // NOTE: non-blocking updates mean a shadow written on the wrap edge is loaded
    // into the active register with its pre-edge value; the new value waits one period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            period_sh_q   <= WIDTH'(DEFAULT_PERIOD);
            period_act_q  <= WIDTH'(DEFAULT_PERIOD);
            period_done_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            period_sh_q   <= period_sh_d;
            period_act_q  <= period_act_d;
            period_done_q <= period_done_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        assign ch_we[i] = cfg_we && (addr_ext >= ADDR_DUTY_BASE)
                          && (chan_of_addr(addr_ext) == 32'(i));

        pwm_channel #(
            .WIDTH        (WIDTH),
            .DEFAULT_DUTY (DEFAULT_DUTY)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en_i    (enable),
            .load_i  (load),
            .we_i    (ch_we[i]),
            .wdata_i (cfg_wdata),
            .cnt_i   (cnt_q),
            .pwm_o   (pwm_out[i])
        );
    end

    assign period_done = period_done_q;

endmodule
